rx_ctrl_timer: RTL and testbench

Receiver control unit and bit timer for the UART receive path. It sits directly upstream of stop_bit_chk and drives its sbc_clear and sbc_enable inputs. The block sequences a packet from the start-bit detector pulse onward and emits mid-bit shift strobes to the receive shift register. After the stop-bit check it issues load_buffer to the receive data buffer, unless a framing error was flagged.

---
 rtl/rx_ctrl_timer.sv | 125 ++++++++++++
 tb/tb_rx_ctrl_timer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl_timer.sv
// rx_ctrl_timer: UART receive control unit and bit timer.
// Sequences one packet from the start-bit detector pulse onward. It produces
// mid-bit shift strobes for the receive shift register and drives the
// clear/enable handshake of the downstream stop-bit checker. After the stop-bit
// check it issues load_buffer unless the checker flagged a framing error.
//
// Every output is a flop. Each flop's next value is decoded from the
// next-state/next-counter values, so an output in a given cycle is a pure
// function of that cycle's state, clk_cnt and bit_cnt. Inputs only steer the
// next state and never reach an output within the same cycle.

module rx_ctrl_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start_bit_detected,
    input  logic framing_error,
    output logic shift_strobe,
    output logic sbc_clear,
    output logic sbc_enable,
    output logic load_buffer,
    output logic busy
);

    // Counter widths. bit_cnt must be able to hold DATA_BITS+1, the count
    // reached after the stop-bit strobe.
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 2);

    // clk_cnt value on which a strobe fires (the middle of the bit period,
    // measured from the detector's start-bit midpoint).
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    // bit_cnt value on the stop-bit strobe: DATA_BITS data strobes precede it.
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RECEIVE = 3'd2,
        SBC_EN  = 3'd3,
        CHECK   = 3'd4,
        LOAD    = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_nxt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_cnt_nxt;

    // Next-state and next-counter logic for the packet sequencer.
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                if (start_bit_detected) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clk_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                state_nxt   = RECEIVE;
            end
            RECEIVE: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = bit_cnt + BW'(1);
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = SBC_EN;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end
            SBC_EN: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                if (framing_error) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered output pulses. A reset aborts any packet
    // in flight and silences every output at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shift_strobe <= 1'b0;
            sbc_clear    <= 1'b0;
            sbc_enable   <= 1'b0;
            load_buffer  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            clk_cnt      <= clk_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift_strobe <= (state_nxt == RECEIVE) && (clk_cnt_nxt == CLK_LAST);
            sbc_clear    <= (state_nxt == CLEAR);
            sbc_enable   <= (state_nxt == SBC_EN);
            load_buffer  <= (state_nxt == LOAD);
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_rx_ctrl_timer.sv
// tb_rx_ctrl_timer: self-checking bench for rx_ctrl_timer.
// A directed vector table covers the good packet, the framing error, ignored
// start pulses, the mid-packet reset and a back-to-back pair through a
// behavioural stop-bit checker. A randomized phase follows. Every cycle is
// also compared against a packet-offset reference model. A second instance
// with CLKS_PER_BIT=4, DATA_BITS=5 is checked against hand-listed cycles.

module tb_rx_ctrl_timer;

    localparam int C          = 10;
    localparam int D          = 8;
    localparam int L          = (D + 1) * C;
    localparam int RAND_BEGIN = 760;
    localparam int TOTAL      = 6760;

    logic clk;
    logic rst;
    logic start_bit_detected;
    logic framing_error;
    logic fe_drv;
    logic shift_strobe;
    logic sbc_clear;
    logic sbc_enable;
    logic load_buffer;
    logic busy;
    logic [4:0] outs;

    logic start2;
    logic fe2;
    logic shift_strobe2;
    logic sbc_clear2;
    logic sbc_enable2;
    logic load_buffer2;
    logic busy2;
    logic [4:0] outs2;

    logic sbc_mode;
    logic stop_bit;
    logic fe_reg;

    int check_count;
    int err_count;

    // Reference model state: packet accepted at cycle m_start.
    bit m_active;
    int m_start;
    bit m_fe;

    int v_strobes[6] = '{5, 9, 13, 17, 21, 25};

    typedef struct {
        int         cyc;
        bit         start;
        bit         fe;
        bit         rst;
        bit         chk;
        logic [4:0] exp;
        bit         fe_chk;
        bit         fe_exp;
    } vec_t;

    vec_t vecs[$];

    rx_ctrl_timer #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clk                (clk),
        .rst                (rst),
        .start_bit_detected (start_bit_detected),
        .framing_error      (framing_error),
        .shift_strobe       (shift_strobe),
        .sbc_clear          (sbc_clear),
        .sbc_enable         (sbc_enable),
        .load_buffer        (load_buffer),
        .busy               (busy)
    );

    rx_ctrl_timer #(.CLKS_PER_BIT(4), .DATA_BITS(5)) dut_var (
        .clk                (clk),
        .rst                (rst),
        .start_bit_detected (start2),
        .framing_error      (fe2),
        .shift_strobe       (shift_strobe2),
        .sbc_clear          (sbc_clear2),
        .sbc_enable         (sbc_enable2),
        .load_buffer        (load_buffer2),
        .busy               (busy2)
    );

    assign outs  = {busy, load_buffer, sbc_enable, shift_strobe, sbc_clear};
    assign outs2 = {busy2, load_buffer2, sbc_enable2, shift_strobe2, sbc_clear2};
    assign framing_error = sbc_mode ? fe_reg : fe_drv;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Behavioural stop-bit checker used for the back-to-back packet phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_reg <= 1'b0;
        end else if (sbc_clear) begin
            fe_reg <= 1'b0;
        end else if (sbc_enable) begin
            fe_reg <= ~stop_bit;
        end
    end

    task automatic add_vec(input int c, input bit s, input bit f, input bit r,
                           input bit ch, input logic [4:0] e);
        vecs.push_back('{c, s, f, r, ch, e, 1'b0, 1'b0});
    endtask

    task automatic add_fe(input int c, input bit e);
        vecs.push_back('{c, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1, e});
    endtask

    task automatic checkOutput(input string name, input int n,
                               input logic [4:0] got, input logic [4:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", name, n, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_start  = 0;
        m_fe     = 1'b0;
    endtask

    // Expected {busy, load, en, strobe, clear} from the offset into the packet.
    function automatic logic [4:0] model_expect(input int n);
        int t;
        bit cl, st, en, ld, bz;
        if (!m_active) return 5'b0;
        t  = n - m_start;
        cl = (t == 1);
        st = (t >= C + 1) && (t <= L + 1) && (((t - 1) % C) == 0);
        en = (t == L + 2);
        ld = (t == L + 4) && !m_fe;
        bz = ((t >= 1) && (t <= L + 3)) || ld;
        return {bz, ld, en, st, cl};
    endfunction

    // Advance the model by one cycle with that cycle's inputs.
    task automatic model_advance(input int n, input bit s, input bit f);
        int t;
        bit idle_now;
        t = n - m_start;
        if (m_active && t == L + 3) m_fe = f;
        idle_now = !m_active || ((t >= L + 4) && m_fe) || (t >= L + 5);
        if (idle_now) begin
            m_active = s;
            if (s) m_start = n;
        end
    endtask

    function automatic logic [4:0] variant_expect(input int n);
        bit st;
        st = 1'b0;
        foreach (v_strobes[i]) if (v_strobes[i] == n) st = 1'b1;
        return {(n >= 1 && n <= 28), (n == 28), (n == 26), st, (n == 1)};
    endfunction

    task automatic applyStimulus(input bit s, input bit f, input bit r, input int n);
        start_bit_detected = s;
        fe_drv             = f;
        start2             = (n == 0);
        if (r) begin
            rst = 1'b1;
            #1;
            checkOutput("async_reset", n, outs, 5'b0);
            checkOutput("async_reset_var", n, outs2, 5'b0);
            rst = 1'b0;
            model_reset();
        end
    endtask

    initial begin
        clk                = 1'b0;
        rst                = 1'b1;
        start_bit_detected = 1'b0;
        fe_drv             = 1'b0;
        start2             = 1'b0;
        fe2                = 1'b0;
        sbc_mode           = 1'b0;
        stop_bit           = 1'b0;
        check_count        = 0;
        err_count          = 0;
        model_reset();

        // Good packet.
        add_vec(0,   1, 0, 0, 1, 5'b00000);
        add_vec(1,   0, 0, 0, 1, 5'b10001);
        add_vec(10,  0, 0, 0, 1, 5'b10000);
        add_vec(11,  0, 0, 0, 1, 5'b10010);
        add_vec(21,  0, 0, 0, 1, 5'b10010);
        add_vec(91,  0, 0, 0, 1, 5'b10010);
        add_vec(92,  0, 0, 0, 1, 5'b10100);
        add_vec(93,  0, 0, 0, 1, 5'b10000);
        add_vec(94,  0, 0, 0, 1, 5'b11000);
        add_vec(95,  0, 0, 0, 1, 5'b00000);
        // Framing error.
        add_vec(100, 1, 0, 0, 0, 5'b00000);
        add_vec(192, 0, 0, 0, 1, 5'b10100);
        add_vec(193, 0, 1, 0, 1, 5'b10000);
        add_vec(194, 0, 0, 0, 1, 5'b00000);
        // Ignored start pulses, then one accepted right after LOAD.
        add_vec(200, 1, 0, 0, 0, 5'b00000);
        add_vec(201, 0, 0, 0, 1, 5'b10001);
        add_vec(205, 1, 0, 0, 1, 5'b10000);
        add_vec(206, 0, 0, 0, 1, 5'b10000);
        add_vec(250, 1, 0, 0, 0, 5'b00000);
        add_vec(291, 0, 0, 0, 1, 5'b10010);
        add_vec(292, 0, 0, 0, 1, 5'b10100);
        add_vec(294, 1, 0, 0, 1, 5'b11000);
        add_vec(295, 1, 0, 0, 1, 5'b00000);
        add_vec(296, 0, 0, 0, 1, 5'b10001);
        add_vec(389, 0, 0, 0, 1, 5'b11000);
        add_vec(390, 0, 0, 0, 1, 5'b00000);
        // Mid-packet reset and clean restart.
        add_vec(400, 1, 0, 0, 0, 5'b00000);
        add_vec(440, 0, 0, 1, 1, 5'b00000);
        add_vec(441, 0, 0, 0, 1, 5'b00000);
        add_vec(450, 1, 0, 0, 1, 5'b00000);
        add_vec(451, 0, 0, 0, 1, 5'b10001);
        add_vec(544, 0, 0, 0, 1, 5'b11000);
        add_vec(545, 0, 0, 0, 1, 5'b00000);
        // Back-to-back through the stop-bit checker: bad then good.
        add_vec(560, 1, 0, 0, 0, 5'b00000);
        add_vec(653, 0, 0, 0, 1, 5'b10000);
        add_fe(653, 1'b1);
        add_vec(654, 1, 0, 0, 1, 5'b00000);
        add_vec(655, 0, 0, 0, 1, 5'b10001);
        add_fe(656, 1'b0);
        add_vec(748, 0, 0, 0, 1, 5'b11000);
        add_vec(749, 0, 0, 0, 1, 5'b00000);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", -1, outs, 5'b0);
        checkOutput("reset_hold_var", -1, outs2, 5'b0);
        rst = 1'b0;

        for (int n = 0; n < TOTAL; n++) begin
            bit s;
            bit f;
            bit r;
            s = 1'b0;
            f = 1'b0;
            r = 1'b0;
            foreach (vecs[i]) begin
                if (vecs[i].cyc == n) begin
                    s |= vecs[i].start;
                    f |= vecs[i].fe;
                    r |= vecs[i].rst;
                end
            end
            if (n >= RAND_BEGIN) begin
                s = ($urandom_range(0, 15) == 0);
                f = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 999) == 0);
            end
            sbc_mode = (n >= 560) && (n < RAND_BEGIN);
            stop_bit = (n >= 654);
            applyStimulus(s, f, r, n);

            @(negedge clk);
            checkOutput("model", n, outs, model_expect(n));
            foreach (vecs[i]) begin
                if (vecs[i].cyc == n && vecs[i].chk)
                    checkOutput("vector", n, outs, vecs[i].exp);
                if (vecs[i].cyc == n && vecs[i].fe_chk)
                    checkOutput("sbc_flag", n, {4'b0, fe_reg}, {4'b0, vecs[i].fe_exp});
            end
            if (n <= 32)
                checkOutput("variant", n, outs2, variant_expect(n));
            model_advance(n, s, framing_error);

            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
